// File: rtl/gfx_pkg.sv
// Shared graphics types and constants for the circle octant serializer path.
package gfx_pkg;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COORD_W = 10;
  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 12;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } pix_wr_t;

  typedef enum logic {IDLE, EMIT} state_t;

  // Evaluated at ADDR_W so the largest on-screen point cannot wrap.
  function automatic logic [ADDR_W-1:0] lin_addr(input point_t p);
    return ADDR_W'(p.y) * ADDR_W'(H_RES) + ADDR_W'(p.x);
  endfunction
endpackage

// File: rtl/circle_octant_serializer_octant_pick.sv
// octant_pick: lowest-set-bit priority encoder over the 8-entry point mask.
module octant_pick (
  input  logic [7:0] i_mask,
  output logic [2:0] o_idx,
  output logic       o_any
);
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = 3'(i);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/circle_octant_serializer.sv
// Serializes one 8-point octant group into one clipped framebuffer write per cycle.
// Build option: CIRCLE_OCTANT_DEDUP_EN drops repeated points within a group at capture.
module circle_octant_serializer
  import gfx_pkg::*;
(
  input  logic               clk,
  input  logic               rst_,
  input  logic [COORD_W-1:0] in_x_0,
  input  logic [COORD_W-1:0] in_x_1,
  input  logic [COORD_W-1:0] in_x_2,
  input  logic [COORD_W-1:0] in_x_3,
  input  logic [COORD_W-1:0] in_x_4,
  input  logic [COORD_W-1:0] in_x_5,
  input  logic [COORD_W-1:0] in_x_6,
  input  logic [COORD_W-1:0] in_x_7,
  input  logic [COORD_W-1:0] in_y_0,
  input  logic [COORD_W-1:0] in_y_1,
  input  logic [COORD_W-1:0] in_y_2,
  input  logic [COORD_W-1:0] in_y_3,
  input  logic [COORD_W-1:0] in_y_4,
  input  logic [COORD_W-1:0] in_y_5,
  input  logic [COORD_W-1:0] in_y_6,
  input  logic [COORD_W-1:0] in_y_7,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_rts,
  output logic               in_rtr,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [COLOR_W-1:0] out_color,
  output logic               out_rts,
  input  logic               out_rtr
);
  // state | meaning
  // IDLE  | accepting a group; output register only drains
  // EMIT  | draining mask lowest index first; upstream stalled

  state_t             r_state;
  point_t             r_pts [8];
  logic [COLOR_W-1:0] r_color;
  logic [7:0]         r_mask;
  pix_wr_t            r_out;
  logic               r_out_rts;
  logic               r_in_rtr;

  point_t     w_in_pts [8];
  logic [7:0] w_cap_mask;
  logic [7:0] w_mask_rest;
  logic [2:0] w_idx;
  logic       w_any;
  logic       w_slot;

  assign w_in_pts[0] = '{x: in_x_0, y: in_y_0};
  assign w_in_pts[1] = '{x: in_x_1, y: in_y_1};
  assign w_in_pts[2] = '{x: in_x_2, y: in_y_2};
  assign w_in_pts[3] = '{x: in_x_3, y: in_y_3};
  assign w_in_pts[4] = '{x: in_x_4, y: in_y_4};
  assign w_in_pts[5] = '{x: in_x_5, y: in_y_5};
  assign w_in_pts[6] = '{x: in_x_6, y: in_y_6};
  assign w_in_pts[7] = '{x: in_x_7, y: in_y_7};

  // Wrapped negatives from the drawer land above the resolution and clip here.
  always_comb begin
    w_cap_mask = '0;
    for (int i = 0; i < 8; i++) begin
      w_cap_mask[i] = (w_in_pts[i].x < COORD_W'(H_RES)) && (w_in_pts[i].y < COORD_W'(V_RES));
    end
`ifdef CIRCLE_OCTANT_DEDUP_EN
    for (int i = 1; i < 8; i++) begin
      for (int j = 0; j < i; j++) begin
        if (w_in_pts[i] == w_in_pts[j]) w_cap_mask[i] = 1'b0;
      end
    end
`endif
  end

  octant_pick u_pick (
    .i_mask (r_mask),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_mask_rest = r_mask & ~(8'b1 << w_idx);
  assign w_slot      = !r_out_rts || out_rtr;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_state   <= IDLE;
      r_color   <= '0;
      r_mask    <= '0;
      r_out     <= '0;
      r_out_rts <= 1'b0;
      r_in_rtr  <= 1'b1;
      for (int i = 0; i < 8; i++) r_pts[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_slot) r_out_rts <= 1'b0;
          if (in_rts) begin
            for (int i = 0; i < 8; i++) r_pts[i] <= w_in_pts[i];
            r_color  <= in_color;
            r_mask   <= w_cap_mask;
            r_state  <= EMIT;
            r_in_rtr <= 1'b0;
          end
        end
        EMIT: begin
          if (!w_any) begin
            if (w_slot) r_out_rts <= 1'b0;
            r_state  <= IDLE;
            r_in_rtr <= 1'b1;
          end else if (w_slot) begin
            r_out.addr  <= lin_addr(r_pts[w_idx]);
            r_out.color <= r_color;
            r_out_rts   <= 1'b1;
            r_mask      <= w_mask_rest;
            // Last point loaded: hand back to upstream while it drains.
            if (w_mask_rest == '0) begin
              r_state  <= IDLE;
              r_in_rtr <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_in_rtr <= 1'b1;
        end
      endcase
    end
  end

  assign in_rtr    = r_in_rtr;
  assign out_addr  = r_out.addr;
  assign out_color = r_out.color;
  assign out_rts   = r_out_rts;
endmodule

// File: tb/tb_circle_octant_serializer.sv
// Directed table-driven bench for circle_octant_serializer, plus stall and reset sequences.
module tb_circle_octant_serializer;
  logic        clk;
  logic        rst_;
  logic [9:0]  tx [8];
  logic [9:0]  ty [8];
  logic [11:0] tcolor;
  logic        in_rts;
  logic        in_rtr;
  logic [18:0] out_addr;
  logic [11:0] out_color;
  logic        out_rts;
  logic        out_rtr;

  circle_octant_serializer dut (
    .clk(clk), .rst_(rst_),
    .in_x_0(tx[0]), .in_x_1(tx[1]), .in_x_2(tx[2]), .in_x_3(tx[3]),
    .in_x_4(tx[4]), .in_x_5(tx[5]), .in_x_6(tx[6]), .in_x_7(tx[7]),
    .in_y_0(ty[0]), .in_y_1(ty[1]), .in_y_2(ty[2]), .in_y_3(ty[3]),
    .in_y_4(ty[4]), .in_y_5(ty[5]), .in_y_6(ty[6]), .in_y_7(ty[7]),
    .in_color(tcolor), .in_rts(in_rts), .in_rtr(in_rtr),
    .out_addr(out_addr), .out_color(out_color), .out_rts(out_rts), .out_rtr(out_rtr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][9:0]  x;
    logic [7:0][9:0]  y;
    logic [11:0]      color;
    logic [3:0]       exp_n;
    logic [7:0][18:0] exp_addr;
  } vec_t;

  typedef int ilist_t [8];

  localparam int NVEC = 5;
  vec_t vecs [NVEC];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pt(input int k, input int i, input int x, input int y);
    vecs[k].x[i] = 10'(x);
    vecs[k].y[i] = 10'(y);
  endtask

  task automatic set_oct(input int k, input int xc, input int yc, input int a, input int b);
    set_pt(k, 0, xc + a, yc + b);
    set_pt(k, 1, xc - a, yc + b);
    set_pt(k, 2, xc + a, yc - b);
    set_pt(k, 3, xc - a, yc - b);
    set_pt(k, 4, xc + b, yc + a);
    set_pt(k, 5, xc - b, yc + a);
    set_pt(k, 6, xc + b, yc - a);
    set_pt(k, 7, xc - b, yc - a);
  endtask

  task automatic set_exp(input int k, input int n, input ilist_t a, input int color);
    vecs[k].exp_n = 4'(n);
    vecs[k].color = 12'(color);
    for (int i = 0; i < 8; i++) vecs[k].exp_addr[i] = 19'(a[i]);
  endtask

  task automatic start_group(input int k);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_rtr && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_rtr_ready", 32'(in_rtr), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tx[i] = vecs[k].x[i];
      ty[i] = vecs[k].y[i];
    end
    tcolor = vecs[k].color;
    in_rts = 1'b1;
    @(posedge clk);
    #1 in_rts = 1'b0;
  endtask

  task automatic run_vec(input int k);
    logic [18:0] got [8];
    int n, first, low, en;
    n = 0; first = -1; low = 0;
    out_rtr = 1'b1;
    start_group(k);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!in_rtr) low++;
      if (out_rts) begin
        if (n < 8) got[n] = out_addr;
        if (first < 0) first = c;
        check("pix_color", 32'(out_color), 32'(vecs[k].color));
        n++;
      end
    end
    en = int'(vecs[k].exp_n);
    check("pix_count", 32'(n), 32'(en));
    check("in_rtr_low_cycles", 32'(low), (en == 0) ? 32'd1 : 32'(en));
    if (en > 0) check("first_latency", 32'(first), 32'd1);
    for (int i = 0; i < en && i < n; i++) check("pix_addr", 32'(got[i]), 32'(vecs[k].exp_addr[i]));
  endtask

  task automatic stall_seq();
    int pat [4] = '{1, 0, 0, 1};
    logic [18:0] got [8];
    logic [18:0] prev_addr;
    logic prev_stall, rts, r;
    int cnt;
    cnt = 0; prev_stall = 1'b0; prev_addr = '0;
    out_rtr = 1'b1;
    start_group(0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rts = out_rts;
      if (prev_stall) begin
        check("stall_rts_held", 32'(rts), 32'd1);
        check("stall_addr_held", 32'(out_addr), 32'(prev_addr));
      end
      r = pat[c % 4][0];
      out_rtr = r;
      if (rts && r) begin
        if (cnt < 8) got[cnt] = out_addr;
        cnt++;
      end
      prev_stall = rts && !r;
      prev_addr = out_addr;
    end
    out_rtr = 1'b1;
    check("stall_count", 32'(cnt), 32'd8);
    for (int i = 0; i < 8 && i < cnt; i++) check("stall_addr", 32'(got[i]), 32'(vecs[0].exp_addr[i]));
  endtask

  task automatic reset_seq();
    int bad;
    bad = 0;
    out_rtr = 1'b1;
    start_group(0);
    repeat (3) @(negedge clk);
    check("pre_rst_rts", 32'(out_rts), 32'd1);
    #2 rst_ = 1'b1;
    #1 check("rst_async_rts", 32'(out_rts), 32'd0);
    @(negedge clk);
    #2 rst_ = 1'b0;
    @(negedge clk);
    check("rst_in_rtr", 32'(in_rtr), 32'd1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_rts) bad++;
    end
    check("rst_group_discarded", 32'(bad), 32'd0);
  endtask

  initial begin
    rst_ = 1'b1;
    in_rts = 1'b0;
    out_rtr = 1'b1;
    tcolor = '0;
    for (int i = 0; i < 8; i++) begin
      tx[i] = '0;
      ty[i] = '0;
    end

    set_oct(0, 100, 100, 4, 3);
    set_exp(0, 8, '{66024, 66016, 62184, 62176, 66663, 66657, 61543, 61537}, 'hABC);

    for (int i = 0; i < 8; i++) set_pt(1, i, 10 * i, 5 * i + 1);
    vecs[1].x[3] = 10'd1020;
    vecs[1].y[6] = 10'd480;
    set_exp(1, 6, '{640, 3850, 7060, 13480, 16690, 23110, 0, 0}, 'h123);

    for (int i = 0; i < 8; i++) set_pt(2, i, 1023, 7 * i);
    set_exp(2, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, 'hF00);

    set_pt(3, 0, 639, 479);
    set_pt(3, 1, 640, 0);
    set_pt(3, 2, 0, 479);
    set_pt(3, 3, 639, 0);
    set_pt(3, 4, 0, 0);
    set_pt(3, 5, 0, 480);
    set_pt(3, 6, 1023, 1023);
    set_pt(3, 7, 638, 479);
    set_exp(3, 5, '{307199, 306560, 639, 0, 307198, 0, 0, 0}, 'h0F0);

    set_oct(4, 50, 50, 0, 0);
`ifdef CIRCLE_OCTANT_DEDUP_EN
    set_exp(4, 1, '{32050, 0, 0, 0, 0, 0, 0, 0}, 'h5A5);
`else
    set_exp(4, 8, '{32050, 32050, 32050, 32050, 32050, 32050, 32050, 32050}, 'h5A5);
`endif

    #12;
    check("rst_out_rts", 32'(out_rts), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_color", 32'(out_color), 32'd0);
    #10 rst_ = 1'b0;
    @(negedge clk);
    check("rst_release_in_rtr", 32'(in_rtr), 32'd1);

    for (int k = 0; k < NVEC; k++) run_vec(k);
    stall_seq();
    reset_seq();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
